// File: rtl/mem_lipo_arb.sv
// Two-requester arbiter for the single-port line-in/parallel-out buffer: line writes vs block reads,
// burst-limited fairness. Optional MEM_LIPO_ARB_STAT_EN adds a saturating contention counter.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module mem_lipo_arb #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req_i,
  input  logic [7:0]                wr_addr_i,
  input  logic [`PIXEL_WIDTH*32-1:0] wr_data_i,
  output logic                      wr_ack_o,
  input  logic                      rd_req_i,
  input  logic [1:0]                rd_sel_i,
  input  logic [1:0]                rd_size_i,
  input  logic [3:0]                rd_4x4_x_i,
  input  logic [3:0]                rd_4x4_y_i,
  input  logic [4:0]                rd_idx_i,
  output logic                      rd_ack_o,
  output logic                      rd_valid_o,
  output logic                      a_wen_o,
  output logic [7:0]                a_addr_o,
  output logic [`PIXEL_WIDTH*32-1:0] a_wdata_o,
  output logic                      b_ren_o,
  output logic [1:0]                b_sel_o,
  output logic [1:0]                b_size_o,
  output logic [3:0]                b_4x4_x_o,
  output logic [3:0]                b_4x4_y_o,
  output logic [4:0]                b_idx_o
`ifdef MEM_LIPO_ARB_STAT_EN
  ,
  output logic [15:0]               conflict_cnt_o
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {OWN_WR = 1'b0, OWN_RD = 1'b1} owner_e;
  typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_OWN_WR = 2'd1, PH_OWN_RD = 2'd2} phase_e;

  owner_e           r_owner;
  owner_e           w_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  phase_e           w_phase;
  logic             w_under;
  logic             w_pick_rd;
  logic             w_gnt_wr;
  logic             w_gnt_rd;
  logic             r_rd_valid;
  owner_e           w_side;

  // Ownership/burst state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_RD;
      r_burst_cnt <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Grant selection and next-state; acks are forced low while reset is asserted
  always_comb begin
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    w_pick_rd       = rd_req_i;
    w_under         = (r_burst_cnt < BURST_MAX);

    if (r_burst_cnt == '0)       w_phase = PH_IDLE;
    else if (r_owner == OWN_WR)  w_phase = PH_OWN_WR;
    else                         w_phase = PH_OWN_RD;

    if (wr_req_i && rd_req_i) begin
      case (w_phase)
        PH_IDLE:   w_pick_rd = (r_owner == OWN_WR);
        PH_OWN_WR: w_pick_rd = !w_under;
        PH_OWN_RD: w_pick_rd = w_under;
        default:   w_pick_rd = 1'b0;
      endcase
    end

    w_gnt_wr = rst_n & wr_req_i & !w_pick_rd;
    w_gnt_rd = rst_n & rd_req_i & w_pick_rd;
    w_side   = w_pick_rd ? OWN_RD : OWN_WR;

    if (!wr_req_i && !rd_req_i) begin
      w_burst_cnt_nxt = '0;
    end else if (w_side == r_owner) begin
      w_burst_cnt_nxt = w_under ? r_burst_cnt + CNT_W'(1) : r_burst_cnt;
    end else begin
      w_owner_nxt     = w_side;
      w_burst_cnt_nxt = CNT_W'(1);
    end
  end

  // Read data appears one cycle after the read grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_valid <= 1'b0;
    else        r_rd_valid <= w_gnt_rd;
  end

  assign wr_ack_o   = w_gnt_wr;
  assign rd_ack_o   = w_gnt_rd;
  assign rd_valid_o = r_rd_valid;

  assign a_wen_o    = w_gnt_wr;
  assign a_addr_o   = w_gnt_wr ? wr_addr_i : '0;
  assign a_wdata_o  = w_gnt_wr ? wr_data_i : '0;
  assign b_ren_o    = w_gnt_rd;
  assign b_sel_o    = w_gnt_rd ? rd_sel_i   : '0;
  assign b_size_o   = w_gnt_rd ? rd_size_i  : '0;
  assign b_4x4_x_o  = w_gnt_rd ? rd_4x4_x_i : '0;
  assign b_4x4_y_o  = w_gnt_rd ? rd_4x4_y_i : '0;
  assign b_idx_o    = w_gnt_rd ? rd_idx_i   : '0;

`ifdef MEM_LIPO_ARB_STAT_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of cycles where both sides request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                r_conflict_cnt <= '0;
    else if (wr_req_i && rd_req_i && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule
